// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions: key-length codes, Nk/Nr lookup, Rcon, S-box table, word helpers, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;
  localparam logic [1:0] KEY_LEN_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Round constants, indexed from 0 for the first use (i == Nk).
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Key length in 32-bit words; the illegal code never reaches a load.
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nk_of = 4'd4;
      KEY_LEN_192: nk_of = 4'd6;
      default:     nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    nr_of = nk_of(key_len) + 4'd6;
  endfunction

  function automatic logic [7:0] sbox_lut(input logic [7:0] a);
    sbox_lut = SBOX[a];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte; shared by key expansion and cipher SubBytes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Table lookup of the substituted byte
  always_comb begin
    out_byte = sbox_lut(in_byte);
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per cycle into a buffer, 128-bit round-key read port.
// Latency: start edge to rk_valid is T-Nk+1 cycles (41/47/53); read port is combinational.
// Backpressure: none; start is only accepted in IDLE/DONE and is ignored while busy.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK    = 8,
  parameter int MAX_WORDS = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  rk_valid,
  output logic                  err,
  output logic [3:0]            num_rounds,
  input  logic [3:0]            rd_idx,
  output logic [127:0]          rd_data
);

  localparam int WIDX = $clog2(MAX_WORDS);

  state_e            state_q, state_d;
  logic [WIDX-1:0]   cnt_q, cnt_d;     // index i of the word being produced
  logic [2:0]        mod_q, mod_d;     // i mod Nk
  logic [3:0]        rcon_q, rcon_d;   // next Rcon entry to use
  logic [3:0]        nk_q, nk_d;
  logic [3:0]        nr_q, nr_d;
  logic              err_q, err_d;

  logic [31:0]       kbuf_q [MAX_WORDS];
  logic [31:0]       key_word [MAX_NK];

  logic              start_ok, start_bad, load_en, exp_en, last_word;
  logic [WIDX-1:0]   total_words;
  logic [31:0]       prev_word, back_word, sub_in, sub_out, temp_word, new_word;
  logic [7:0]        rcon_byte;
  logic [WIDX-1:0]   rd_base;

  assign start_ok    = start && (state_q != ST_EXPAND) && (key_len != KEY_LEN_ILL);
  assign start_bad   = start && (state_q != ST_EXPAND) && (key_len == KEY_LEN_ILL);
  assign load_en     = start_ok;
  assign exp_en      = (state_q == ST_EXPAND);
  assign total_words = WIDX'({nr_q, 2'b00}) + WIDX'(4);
  assign last_word   = (cnt_q == total_words - WIDX'(1));

  // Split the left-aligned key into words, w[0] from the MSBs
  always_comb begin
    for (int j = 0; j < MAX_NK; j++) begin
      key_word[j] = key_in[32*(MAX_NK-j)-1 -: 32];
    end
  end

  // One key-schedule step: temp from w[i-1], then w[i] = w[i-Nk] ^ temp
  always_comb begin
    prev_word = kbuf_q[cnt_q - WIDX'(1)];
    back_word = kbuf_q[cnt_q - WIDX'(nk_q)];
    sub_in    = (mod_q == 3'd0) ? rot_word(prev_word) : prev_word;
    rcon_byte = (rcon_q < 4'd10) ? RCON[rcon_q] : 8'h00;
    if (mod_q == 3'd0) begin
      temp_word = sub_out ^ {rcon_byte, 24'h0};
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      temp_word = sub_out;
    end else begin
      temp_word = prev_word;
    end
    new_word = back_word ^ temp_word;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok)  state_d = ST_EXPAND;
      ST_EXPAND:        if (last_word) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Counters, key-length latches and the illegal-length pulse
  always_comb begin
    cnt_d  = cnt_q;
    mod_d  = mod_q;
    rcon_d = rcon_q;
    nk_d   = nk_q;
    nr_d   = nr_q;
    err_d  = start_bad;
    if (load_en) begin
      nk_d   = nk_of(key_len);
      nr_d   = nr_of(key_len);
      cnt_d  = WIDX'(nk_of(key_len));
      mod_d  = 3'd0;
      rcon_d = 4'd0;
    end else if (exp_en) begin
      cnt_d = cnt_q + WIDX'(1);
      mod_d = ({1'b0, mod_q} == (nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
      if (mod_q == 3'd0) rcon_d = rcon_q + 4'd1;
    end
  end

  // Schedule buffer: key load in the start cycle, one derived word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int j = 0; j < MAX_NK; j++) begin
        kbuf_q[j] <= key_word[j];
      end
    end else if (exp_en) begin
      kbuf_q[cnt_q] <= new_word;
    end
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q == ST_EXPAND);
    rk_valid = (state_q == ST_DONE);
  end

  assign err        = err_q;
  assign num_rounds = nr_q;

  // Combinational round-key read, zero when no schedule or index beyond Nr
  always_comb begin
    rd_base = WIDX'({rd_idx, 2'b00});
    rd_data = '0;
    if (rk_valid && (rd_idx <= nr_q)) begin
      rd_data = {kbuf_q[rd_base], kbuf_q[rd_base + WIDX'(1)],
                 kbuf_q[rd_base + WIDX'(2)], kbuf_q[rd_base + WIDX'(3)]};
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for the sequential AES key schedule: FIPS-197 vectors, latency, errors, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         err;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .key_in     (key_in),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .err        (err),
    .num_rounds (num_rounds),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  // Pulse start for one edge; returns #1 after that edge
  task automatic apply_start(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    start   = 1'b1;
    key_len = kl;
    key_in  = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (start edge = 1) until rk_valid, bounded
  task automatic wait_valid(input int from, output int cycles);
    cycles = from;
    while (rk_valid !== 1'b1 && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx);
    @(negedge clk);
    rd_idx = idx;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key_in = '0; rd_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (rk_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rk_valid got %b want 0", rk_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (num_rounds !== 4'd0) begin miscompares++; $display("FAIL reset_num_rounds got %0d want 0", num_rounds); end
    vectors++; if (rd_data !== 128'h0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aes128_fips;
    int cyc;
    apply_start(2'b00, {K128A, 128'h0});
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL a128_busy got %b want 1", busy); end
    vectors++; if (rk_valid !== 1'b0) begin miscompares++; $display("FAIL a128_rk_valid_early got %b want 0", rk_valid); end
    wait_valid(1, cyc);
    vectors++; if (cyc !== 41) begin miscompares++; $display("FAIL a128_latency got %0d want 41", cyc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL a128_busy_done got %b want 0", busy); end
    vectors++; if (num_rounds !== 4'd10) begin miscompares++; $display("FAIL a128_num_rounds got %0d want 10", num_rounds); end
    read_rk(4'd0);
    vectors++; if (rd_data !== K128A) begin miscompares++; $display("FAIL a128_rk0 got %h want %h", rd_data, K128A); end
    read_rk(4'd10);
    vectors++; if (rd_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin miscompares++; $display("FAIL a128_rk10 got %h want 13111d7fe3944a17f307a78b4d2b30c5", rd_data); end
    read_rk(4'd11);
    vectors++; if (rd_data !== 128'h0) begin miscompares++; $display("FAIL a128_rk11 got %h want 0", rd_data); end
  endtask

  task automatic test_illegal_key_len;
    apply_start(2'b11, {K128B, 128'h0});
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_err_pulse got %b want 1", err); end
    vectors++; if (rk_valid !== 1'b1) begin miscompares++; $display("FAIL ill_rk_valid got %b want 1", rk_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ill_busy got %b want 0", busy); end
    @(posedge clk);
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ill_err_one_cycle got %b want 0", err); end
    vectors++; if (num_rounds !== 4'd10) begin miscompares++; $display("FAIL ill_num_rounds got %0d want 10", num_rounds); end
    read_rk(4'd10);
    vectors++; if (rd_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin miscompares++; $display("FAIL ill_rk10_kept got %h want 13111d7fe3944a17f307a78b4d2b30c5", rd_data); end
  endtask

  task automatic test_aes128_2b7e;
    int cyc;
    apply_start(2'b00, {K128B, 128'h0});
    wait_valid(1, cyc);
    vectors++; if (cyc !== 41) begin miscompares++; $display("FAIL b128_latency got %0d want 41", cyc); end
    read_rk(4'd1);
    vectors++; if (rd_data[127:96] !== 32'ha0fafe17) begin miscompares++; $display("FAIL b128_w4 got %h want a0fafe17", rd_data[127:96]); end
    read_rk(4'd10);
    vectors++; if (rd_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin miscompares++; $display("FAIL b128_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_data); end
  endtask

  task automatic test_aes192;
    int cyc;
    apply_start(2'b01, {K192, 64'h0});
    wait_valid(1, cyc);
    vectors++; if (cyc !== 47) begin miscompares++; $display("FAIL a192_latency got %0d want 47", cyc); end
    vectors++; if (num_rounds !== 4'd12) begin miscompares++; $display("FAIL a192_num_rounds got %0d want 12", num_rounds); end
    read_rk(4'd12);
    vectors++; if (rd_data !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin miscompares++; $display("FAIL a192_rk12 got %h want a4970a331a78dc09c418c271e3a41d5d", rd_data); end
    read_rk(4'd13);
    vectors++; if (rd_data !== 128'h0) begin miscompares++; $display("FAIL a192_rk13 got %h want 0", rd_data); end
  endtask

  task automatic test_aes256;
    int cyc;
    apply_start(2'b10, K256);
    wait_valid(1, cyc);
    vectors++; if (cyc !== 53) begin miscompares++; $display("FAIL a256_latency got %0d want 53", cyc); end
    vectors++; if (num_rounds !== 4'd14) begin miscompares++; $display("FAIL a256_num_rounds got %0d want 14", num_rounds); end
    read_rk(4'd0);
    vectors++; if (rd_data !== K256[255:128]) begin miscompares++; $display("FAIL a256_rk0 got %h want %h", rd_data, K256[255:128]); end
    read_rk(4'd14);
    vectors++; if (rd_data !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin miscompares++; $display("FAIL a256_rk14 got %h want 24fc79ccbf0979e9371ac23c6d68de36", rd_data); end
  endtask

  task automatic test_start_during_expand;
    int cyc;
    apply_start(2'b00, {K128A, 128'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    start   = 1'b1;
    key_len = 2'b10;
    key_in  = {K128B, K128B};
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL busy_start_err got %b want 0", err); end
    vectors++; if (num_rounds !== 4'd10) begin miscompares++; $display("FAIL busy_start_num_rounds got %0d want 10", num_rounds); end
    wait_valid(5, cyc);
    vectors++; if (cyc !== 41) begin miscompares++; $display("FAIL busy_start_latency got %0d want 41", cyc); end
    read_rk(4'd10);
    vectors++; if (rd_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin miscompares++; $display("FAIL busy_start_rk10 got %h want 13111d7fe3944a17f307a78b4d2b30c5", rd_data); end
  endtask

  task automatic test_reset_mid_expand;
    int cyc;
    apply_start(2'b10, K256);
    repeat (18) @(posedge clk);
    @(negedge clk);
    rd_idx = 4'd0;
    rst_n  = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++; if (rk_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rk_valid got %b want 0", rk_valid); end
    vectors++; if (rd_data !== 128'h0) begin miscompares++; $display("FAIL midrst_rd_data got %h want 0", rd_data); end
    vectors++; if (num_rounds !== 4'd0) begin miscompares++; $display("FAIL midrst_num_rounds got %0d want 0", num_rounds); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stays_idle got busy=%b rk_valid=%b want 0 0", busy, rk_valid); end
    apply_start(2'b01, {K192, 64'h0});
    wait_valid(1, cyc);
    vectors++; if (cyc !== 47) begin miscompares++; $display("FAIL midrst_restart_latency got %0d want 47", cyc); end
    read_rk(4'd12);
    vectors++; if (rd_data !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin miscompares++; $display("FAIL midrst_restart_rk12 got %h want a4970a331a78dc09c418c271e3a41d5d", rd_data); end
  endtask

  initial begin
    test_reset();
    test_aes128_fips();
    test_illegal_key_len();
    test_aes128_2b7e();
    test_aes192();
    test_aes256();
    test_start_during_expand();
    test_reset_mid_expand();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES key-schedule engine, directly upstream of the Cipher stage.
- Accepts a 128/192/256-bit cipher key and generates the full round-key schedule one 32-bit word per cycle into an internal buffer.
- Cipher stages read a 128-bit round key by index through a combinational read port.
- Replaces the repeated combinational key expansion with one area-lean shared unit.

Parameters:
- MAX_NK, 8, largest key length in 32-bit words; sizes key_in and the buffer.
- MAX_WORDS, 60, buffer depth in words, 4*(14+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to expand key_in; sampled only in IDLE or DONE
- key_len  in  2  00=128, 01=192, 10=256, 11=illegal
- key_in  in  256  key, left-aligned; a 128-bit key occupies [255:128]; unused LSBs ignored
- busy  out  1  high while expanding
- rk_valid  out  1  high when the schedule is complete and readable
- err  out  1  one-cycle pulse when start arrives with key_len=11
- num_rounds  out  4  Nr of the current schedule: 10/12/14; 0 after reset
- rd_idx  in  4  round-key index, 0..Nr
- rd_data  out  128  words 4*rd_idx..4*rd_idx+3, w[4i] in MSBs; combinational from buffer

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, rk_valid=0, err=0, num_rounds=0; word counter=0; buffer contents don't-care, but rd_data must read 0 while rk_valid=0.
- Definitions: Nk=4/6/8, Nr=Nk+6, total words T=4*(Nr+1)=44/52/60.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE + start + legal key_len:
  - Same edge: w[0..Nk-1] load from key_in; Nk/Nr latch; num_rounds updates; counter i=Nk.
  - rk_valid drops to 0; busy=1; go to EXPAND.
- IDLE/DONE + start + key_len=11: err=1 for one cycle; state, schedule and rk_valid unchanged.
- EXPAND, one word per cycle, temp=w[i-1]:
  - i mod Nk == 0: temp = SubWord(RotWord(temp)) XOR (Rcon[i/Nk] << 24).
  - Nk=8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] XOR temp; i increments.
- Termination: the cycle writing w[T-1] moves to DONE; next cycle busy=0, rk_valid=1.
- Latency from the start edge to rk_valid=1 is T-Nk+1 cycles: 41 (128), 47 (192), 53 (256).
- start during EXPAND: ignored, no err, expansion continues unaffected.
- Reset mid-expansion: immediately IDLE, rk_valid=0; a fresh start is required.
- i mod Nk is held in a modulo counter that wraps at Nk, so no divider is needed; a separate Rcon index increments on each wrap.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36; generated by xtime or table lookup.
- rd_data:
  - rk_valid=0 or rd_idx>Nr: rd_data=0.
  - Otherwise rd_data reflects rd_idx in the same cycle, with no register.
- The buffer is written only in the load cycle and in EXPAND.

Decomposition:
- Shared package aes_pkg:
  - KEY_LEN_128/192/256 encodings
  - NK/NR lookup functions
  - RCON constant array
  - SubWord and RotWord function declarations
  - FSM state enum
- One natural sub-module: aes_sbox (combinational 8-bit S-box), instantiated 4x for SubWord.
- The same aes_sbox is reused by the Cipher SubBytes stage.

Test Plan:
- 128-bit key 000102030405060708090a0b0c0d0e0f:
  - rk_valid after 41 cycles; num_rounds=10.
  - rd_idx=0 -> 000102030405060708090a0b0c0d0e0f.
  - rd_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c: rd_idx=1 word0=a0fafe17; rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- 192-bit key 000102...1617: rk_valid after 47 cycles; num_rounds=12; rd_idx=12 -> a4970a331a78dc09c418c271e3a41d5d.
- 256-bit key 000102...1e1f: rk_valid after 53 cycles; num_rounds=14; rd_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- key_len=11 with start from DONE: err pulses 1 cycle; rk_valid stays 1; rd_idx=10 still returns the previous schedule. Also, rd_idx=11 on a 128-bit schedule returns 0.
- Second start and reset during EXPAND:
  - Second start at cycle 5 is ignored: completes at cycle 41 with the first key's results.
  - rst_n low at cycle 20: busy=0, rk_valid=0, rd_data=0 immediately.
  - A new start after release completes normally.
